// File: rtl/parameter_pkg.sv
// Shared types and widths for the I2C target responder and its bus synchronizer.
package parameter_pkg;

  localparam int I2C_ADDR_WIDTH = 7;
  localparam int I2C_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } i2c_tgt_state_t;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } i2c_op_t;

  // Bit counter advance that holds at the limit instead of wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] cnt, input logic [3:0] lim);
    return (cnt >= lim) ? cnt : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into clk_i and emits registered one-cycle pulses for
// SCL edges and START/STOP conditions. SYNC_STAGES must be at least 2.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_sync
);

  logic [SYNC_STAGES-1:0] scl_ff;
  logic [SYNC_STAGES-1:0] sda_ff;
  logic scl_s;
  logic sda_s;
  logic scl_q;
  logic sda_q;

  assign scl_s    = scl_ff[SYNC_STAGES-1];
  assign sda_s    = sda_ff[SYNC_STAGES-1];
  assign sda_sync = sda_q;

  // Chains preset to 1 so a freshly reset block sees an idle bus.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_ff    <= '1;
      sda_ff    <= '1;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_ff    <= {scl_ff[SYNC_STAGES-2:0], scl_i};
      sda_ff    <= {sda_ff[SYNC_STAGES-2:0], sda_i};
      scl_q     <= scl_s;
      sda_q     <= sda_s;
      scl_rise  <= scl_s & ~scl_q;
      scl_fall  <= ~scl_s & scl_q;
      start_det <= scl_s & scl_q & sda_q & ~sda_s;
      stop_det  <= scl_s & scl_q & ~sda_q & sda_s;
    end
  end

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target endpoint: decodes START/STOP, matches TARGET_ADDR, streams write
// bytes out and fetches read bytes in. FSM state is exposed on state_o.
module i2c_target_responder
  import parameter_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h22,
  parameter int         SYNC_STAGES = 2,
  parameter int         DATA_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_drive_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  wr_valid_o,
  output logic                  rd_req_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  start_o,
  output logic                  stop_o,
  output logic                  busy_o,
  output logic                  rw_o,
  output logic                  nack_o,
  output i2c_tgt_state_t        state_o
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH);

  logic scl_rise, scl_fall, start_det, stop_det, sda_sync;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bus_sync (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_sync  (sda_sync)
  );

  i2c_tgt_state_t state, state_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n, wr_data_q, wr_data_n, byte_in;
  logic drive, drive_n;
  i2c_op_t op_q, op_n;
  logic wr_valid_q, wr_valid_n, start_q, start_n, stop_q, stop_n;
  logic busy_q, busy_n, nack_q, nack_n, rd_req;

  assign byte_in = {shreg[DATA_WIDTH-2:0], sda_sync};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      drive      <= 1'b0;
      op_q       <= WRITE;
      wr_data_q  <= '0;
      wr_valid_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      drive      <= drive_n;
      op_q       <= op_n;
      wr_data_q  <= wr_data_n;
      wr_valid_q <= wr_valid_n;
      start_q    <= start_n;
      stop_q     <= stop_n;
      busy_q     <= busy_n;
      nack_q     <= nack_n;
    end
  end

  // Byte streams carry no back-pressure: wr_valid_o is a one-cycle pulse with
  // wr_data_o stable alongside it, and rd_data_i is captured at the end of the
  // cycle in which rd_req_o is high, so the source must already present it.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    drive_n    = drive;
    op_n       = op_q;
    wr_data_n  = wr_data_q;
    wr_valid_n = 1'b0;
    start_n    = 1'b0;
    stop_n     = 1'b0;
    busy_n     = busy_q;
    nack_n     = 1'b0;
    rd_req     = 1'b0;
    if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      drive_n   = 1'b0;
      start_n   = 1'b1;
      busy_n    = 1'b1;
    end else if (stop_det) begin
      if (state != IDLE) begin
        state_n   = IDLE;
        bit_cnt_n = '0;
        drive_n   = 1'b0;
        stop_n    = 1'b1;
        busy_n    = 1'b0;
      end
    end else begin
      case (state)
        ADDR: if (scl_rise) begin
          shreg_n   = byte_in;
          bit_cnt_n = sat_inc(bit_cnt, LAST_BIT);
          if (bit_cnt == LAST_BIT - 4'd1) begin
            if (byte_in[DATA_WIDTH-1:1] == TARGET_ADDR) begin
              op_n    = i2c_op_t'(byte_in[0]);
              state_n = ADDR_ACK;
            end else begin
              state_n = IGNORE;
            end
          end
        end
        // drive doubles as the phase flag: first fall asserts ACK, second ends it.
        ADDR_ACK: if (scl_fall) begin
          if (!drive) begin
            drive_n = 1'b1;
          end else if (op_q == READ) begin
            rd_req    = 1'b1;
            shreg_n   = rd_data_i;
            drive_n   = ~rd_data_i[DATA_WIDTH-1];
            bit_cnt_n = 4'd1;
            state_n   = RD_DATA;
          end else begin
            drive_n   = 1'b0;
            bit_cnt_n = '0;
            state_n   = WR_DATA;
          end
        end
        WR_DATA: if (scl_rise) begin
          shreg_n   = byte_in;
          bit_cnt_n = sat_inc(bit_cnt, LAST_BIT);
          if (bit_cnt == LAST_BIT - 4'd1) begin
            wr_data_n  = byte_in;
            wr_valid_n = 1'b1;
            state_n    = WR_ACK;
          end
        end
        WR_ACK: if (scl_fall) begin
          if (!drive) begin
            drive_n = 1'b1;
          end else begin
            drive_n   = 1'b0;
            bit_cnt_n = '0;
            state_n   = WR_DATA;
          end
        end
        RD_DATA: if (scl_fall) begin
          if (bit_cnt == LAST_BIT) begin
            drive_n = 1'b0;
            state_n = RD_ACK;
          end else begin
            drive_n   = ~shreg[DATA_WIDTH-2];
            shreg_n   = {shreg[DATA_WIDTH-2:0], 1'b0};
            bit_cnt_n = sat_inc(bit_cnt, LAST_BIT);
          end
        end
        RD_ACK: begin
          if (scl_rise && sda_sync) begin
            nack_n  = 1'b1;
            state_n = IGNORE;
          end else if (scl_fall) begin
            rd_req    = 1'b1;
            shreg_n   = rd_data_i;
            drive_n   = ~rd_data_i[DATA_WIDTH-1];
            bit_cnt_n = 4'd1;
            state_n   = RD_DATA;
          end
        end
        IDLE, IGNORE: ;
        default: state_n = IDLE;
      endcase
    end
  end

  assign sda_drive_o = drive;
  assign wr_data_o   = wr_data_q;
  assign wr_valid_o  = wr_valid_q;
  assign rd_req_o    = rd_req;
  assign start_o     = start_q;
  assign stop_o      = stop_q;
  assign busy_o      = busy_q;
  assign rw_o        = op_q;
  assign nack_o      = nack_q;
  assign state_o     = state;

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: a behavioural I2C master drives the bus and a
// transaction-level model predicts ACKs, delivered bytes and pulse counts.
`timescale 1ns/1ps
module tb_i2c_target_responder;
  import parameter_pkg::*;

  localparam logic [6:0] TGT = 7'h22;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic scl_m, sda_m, sda_bus;
  logic sda_drive_o, wr_valid_o, rd_req_o, start_o, stop_o, busy_o, rw_o, nack_o;
  logic [7:0] wr_data_o, rd_data_i;
  i2c_tgt_state_t state_o;

  assign sda_bus = sda_m & ~sda_drive_o;

  i2c_target_responder #(.TARGET_ADDR(TGT), .SYNC_STAGES(2), .DATA_WIDTH(8)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .scl_i       (scl_m),
    .sda_i       (sda_bus),
    .sda_drive_o (sda_drive_o),
    .wr_data_o   (wr_data_o),
    .wr_valid_o  (wr_valid_o),
    .rd_req_o    (rd_req_o),
    .rd_data_i   (rd_data_i),
    .start_o     (start_o),
    .stop_o      (stop_o),
    .busy_o      (busy_o),
    .rw_o        (rw_o),
    .nack_o      (nack_o),
    .state_o     (state_o)
  );

  // ---------------- read-byte source and monitor ----------------
  logic [7:0] rd_bytes [16];
  int rd_ptr = 0;
  assign rd_data_i = rd_bytes[rd_ptr[3:0]];
  always @(posedge clk) if (rd_req_o) rd_ptr <= rd_ptr + 1;

  int n_start = 0, n_stop = 0, n_rd_req = 0, n_nack = 0, n_drive = 0;
  logic [7:0] got_q[$];
  always @(negedge clk) begin
    if (wr_valid_o) got_q.push_back(wr_data_o);
    if (start_o) n_start++;
    if (stop_o) n_stop++;
    if (rd_req_o) n_rd_req++;
    if (nack_o) n_nack++;
    if (sda_drive_o) n_drive++;
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0, n_fail = 0;
  logic [7:0] exp_q[$];
  int b_start, b_stop, b_rd_req, b_nack, b_drive, b_got;
  logic [7:0] tx_bytes [4];
  logic [7:0] rx_bytes [4];

  task automatic snap();
    b_start = n_start; b_stop = n_stop; b_rd_req = n_rd_req;
    b_nack = n_nack; b_drive = n_drive; b_got = got_q.size();
    exp_q.delete();
  endtask

  // ---------------- bus driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    cyc(2); sda_m = 1'b1; cyc(6); scl_m = 1'b1; cyc(8); sda_m = 1'b0; cyc(8); scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    cyc(2); sda_m = 1'b0; cyc(6); scl_m = 1'b1; cyc(8); sda_m = 1'b1; cyc(8);
  endtask

  task automatic bus_bit(input logic b, output logic s);
    cyc(2); sda_m = b; cyc(6); scl_m = 1'b1; cyc(4); s = sda_bus; cyc(4); scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
    bus_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
    end
    bus_bit(~ack, s);
  endtask

  task automatic wr_xfer(input logic [6:0] a, input int n, output logic [4:0] acks);
    logic k;
    acks = '0;
    send_byte({a, 1'b0}, k);
    acks[0] = k;
    for (int i = 0; i < n; i++) begin
      send_byte(tx_bytes[i], k);
      acks[i+1] = k;
    end
  endtask

  task automatic rd_xfer(input logic [6:0] a, input int n, output logic addr_ack);
    logic k;
    send_byte({a, 1'b1}, k);
    addr_ack = k;
    if (k) for (int i = 0; i < n; i++) recv_byte(i != n - 1, rx_bytes[i]);
  endtask

  // Transaction model: a write ACKs the address and every byte only when the
  // address matches, and then every byte is delivered in order.
  function automatic logic [4:0] model_wr_acks(input logic [6:0] a, input int n);
    return (a == TGT) ? 5'((1 << (n + 1)) - 1) : 5'd0;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    cyc(3);
    n_cmp++;
    if ({sda_drive_o, wr_valid_o, rd_req_o, start_o, stop_o, busy_o, rw_o, nack_o, wr_data_o} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {sda_drive_o, wr_valid_o, rd_req_o, start_o, stop_o, busy_o, rw_o, nack_o, wr_data_o});
    end
    n_cmp++;
    if (state_o !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", state_o, IDLE); end
    rst_n = 1'b1;
    snap();
    cyc(10);
    n_cmp++;
    if (n_start - b_start != 0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_false_edge: starts %0d busy %b expected 0/0", n_start - b_start, busy_o);
    end
  endtask

  task automatic test_write_basic();
    logic [4:0] acks;
    snap();
    tx_bytes[0] = 8'hA5; tx_bytes[1] = 8'h3C;
    exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
    bus_start();
    wr_xfer(TGT, 2, acks);
    n_cmp++;
    if (busy_o !== 1'b1 || rw_o !== 1'b0) begin
      n_fail++; $display("FAIL write_busy_rw: busy %b rw %b expected 1/0", busy_o, rw_o);
    end
    bus_stop();
    n_cmp++;
    if (acks[2:0] !== model_wr_acks(TGT, 2)) begin
      n_fail++; $display("FAIL write_acks: got %b expected %b", acks[2:0], model_wr_acks(TGT, 2));
    end
    n_cmp++;
    if (got_q.size() - b_got != exp_q.size()) begin
      n_fail++; $display("FAIL write_count: got %0d expected %0d", got_q.size() - b_got, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (got_q[b_got + i] !== exp_q[i]) begin
          n_fail++; $display("FAIL write_data[%0d]: got %h expected %h", i, got_q[b_got + i], exp_q[i]);
        end
      end
    end
    n_cmp++;
    if (n_start - b_start != 1 || n_stop - b_stop != 1 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL write_start_stop: starts %0d stops %0d busy %b expected 1/1/0",
                         n_start - b_start, n_stop - b_stop, busy_o);
    end
  endtask

  task automatic test_addr_miss();
    logic [4:0] acks;
    logic [6:0] a;
    for (int t = 0; t < 2; t++) begin
      a = (t == 0) ? 7'h23 : 7'($urandom_range(0, 127));
      if (a == TGT) a = a ^ 7'h01;
      snap();
      tx_bytes[0] = (t == 0) ? 8'hFF : 8'($urandom);
      bus_start();
      wr_xfer(a, 1, acks);
      n_cmp++;
      if (state_o !== IGNORE) begin n_fail++; $display("FAIL miss_state: got %0d expected %0d", state_o, IGNORE); end
      bus_stop();
      n_cmp++;
      if (acks[1:0] !== model_wr_acks(a, 1)) begin
        n_fail++; $display("FAIL miss_acks: addr %h got %b expected %b", a, acks[1:0], model_wr_acks(a, 1));
      end
      n_cmp++;
      if (n_drive - b_drive != 0 || got_q.size() - b_got != 0) begin
        n_fail++; $display("FAIL miss_quiet: drive cycles %0d bytes %0d expected 0/0", n_drive - b_drive, got_q.size() - b_got);
      end
      n_cmp++;
      if (state_o !== IDLE) begin n_fail++; $display("FAIL miss_idle: got %0d expected %0d", state_o, IDLE); end
    end
  endtask

  task automatic test_read();
    logic ack;
    snap();
    rd_bytes[4'(rd_ptr)] = 8'h5A; rd_bytes[4'(rd_ptr + 1)] = 8'hC3;
    exp_q.push_back(8'h5A); exp_q.push_back(8'hC3);
    bus_start();
    rd_xfer(TGT, 2, ack);
    n_cmp++;
    if (rw_o !== 1'b1) begin n_fail++; $display("FAIL read_rw: got %b expected 1", rw_o); end
    bus_stop();
    n_cmp++;
    if (ack !== 1'b1) begin n_fail++; $display("FAIL read_addr_ack: got %b expected 1", ack); end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (rx_bytes[i] !== exp_q[i]) begin n_fail++; $display("FAIL read_data[%0d]: got %h expected %h", i, rx_bytes[i], exp_q[i]); end
    end
    n_cmp++;
    if (n_rd_req - b_rd_req != 2 || n_nack - b_nack != 1 || sda_drive_o !== 1'b0) begin
      n_fail++; $display("FAIL read_pulses: rd_req %0d nack %0d drive %b expected 2/1/0",
                         n_rd_req - b_rd_req, n_nack - b_nack, sda_drive_o);
    end
  endtask

  task automatic test_repeated_start();
    logic [4:0] acks;
    logic ack;
    logic [7:0] rb;
    snap();
    tx_bytes[0] = 8'h11;
    exp_q.push_back(8'h11);
    rb = 8'($urandom);
    bus_start();
    wr_xfer(TGT, 1, acks);
    n_cmp++;
    if (rw_o !== 1'b0 || acks[1:0] !== 2'b11) begin
      n_fail++; $display("FAIL rs_write_phase: rw %b acks %b expected 0/11", rw_o, acks[1:0]);
    end
    rd_bytes[4'(rd_ptr)] = rb;
    bus_start();
    rd_xfer(TGT, 1, ack);
    n_cmp++;
    if (rw_o !== 1'b1 || ack !== 1'b1) begin n_fail++; $display("FAIL rs_read_phase: rw %b ack %b expected 1/1", rw_o, ack); end
    bus_stop();
    n_cmp++;
    if (rx_bytes[0] !== rb) begin n_fail++; $display("FAIL rs_read_data: got %h expected %h", rx_bytes[0], rb); end
    n_cmp++;
    if (n_start - b_start != 2 || n_rd_req - b_rd_req != 1 || got_q.size() - b_got != 1) begin
      n_fail++; $display("FAIL rs_counts: starts %0d rd_req %0d bytes %0d expected 2/1/1",
                         n_start - b_start, n_rd_req - b_rd_req, got_q.size() - b_got);
    end else begin
      n_cmp++;
      if (got_q[b_got] !== exp_q[0]) begin n_fail++; $display("FAIL rs_write_data: got %h expected %h", got_q[b_got], exp_q[0]); end
    end
  endtask

  task automatic test_partial_stop();
    logic k, s;
    logic [4:0] acks;
    snap();
    bus_start();
    send_byte({TGT, 1'b0}, k);
    for (int i = 0; i < 4; i++) bus_bit(1'($urandom), s);
    bus_stop();
    n_cmp++;
    if (got_q.size() - b_got != 0 || n_stop - b_stop != 1) begin
      n_fail++; $display("FAIL partial_discard: bytes %0d stops %0d expected 0/1", got_q.size() - b_got, n_stop - b_stop);
    end
    tx_bytes[0] = 8'h77;
    exp_q.push_back(8'h77);
    bus_start();
    wr_xfer(TGT, 1, acks);
    bus_stop();
    n_cmp++;
    if (got_q.size() - b_got != 1 || acks[1:0] !== 2'b11) begin
      n_fail++; $display("FAIL partial_next_count: bytes %0d acks %b expected 1/11", got_q.size() - b_got, acks[1:0]);
    end else begin
      n_cmp++;
      if (got_q[b_got] !== exp_q[0]) begin n_fail++; $display("FAIL partial_next_data: got %h expected %h", got_q[b_got], exp_q[0]); end
    end
  endtask

  task automatic test_reset_during_ack();
    logic s;
    logic [4:0] acks;
    logic [7:0] addr_byte;
    addr_byte = {TGT, 1'b0};
    bus_start();
    for (int i = 7; i >= 0; i--) bus_bit(addr_byte[i], s);
    cyc(2); sda_m = 1'b1; cyc(5);
    n_cmp++;
    if (sda_drive_o !== 1'b1) begin n_fail++; $display("FAIL rst_ack_driving: got %b expected 1", sda_drive_o); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({sda_drive_o, wr_valid_o, rd_req_o, start_o, stop_o, busy_o, rw_o, nack_o, wr_data_o} !== 16'h0 || state_o !== IDLE) begin
      n_fail++; $display("FAIL rst_async: outputs %h state %0d expected 0/0",
                         {sda_drive_o, wr_valid_o, rd_req_o, start_o, stop_o, busy_o, rw_o, nack_o, wr_data_o}, state_o);
    end
    scl_m = 1'b1; sda_m = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    cyc(5);
    snap();
    tx_bytes[0] = 8'($urandom);
    exp_q.push_back(tx_bytes[0]);
    bus_start();
    wr_xfer(TGT, 1, acks);
    bus_stop();
    n_cmp++;
    if (n_start - b_start != 1 || acks[1:0] !== 2'b11 || got_q.size() - b_got != 1) begin
      n_fail++; $display("FAIL rst_recover: starts %0d acks %b bytes %0d expected 1/11/1",
                         n_start - b_start, acks[1:0], got_q.size() - b_got);
    end else begin
      n_cmp++;
      if (got_q[b_got] !== exp_q[0]) begin n_fail++; $display("FAIL rst_recover_data: got %h expected %h", got_q[b_got], exp_q[0]); end
    end
  endtask

  task automatic test_random();
    logic [6:0] a;
    logic rw, ack;
    logic [4:0] acks;
    int n;
    for (int t = 0; t < 6; t++) begin
      a  = ($urandom_range(0, 2) != 0) ? TGT : 7'($urandom_range(0, 127));
      rw = 1'($urandom);
      n  = $urandom_range(1, 3);
      snap();
      bus_start();
      if (!rw) begin
        for (int i = 0; i < n; i++) begin
          tx_bytes[i] = 8'($urandom);
          if (a == TGT) exp_q.push_back(tx_bytes[i]);
        end
        wr_xfer(a, n, acks);
        bus_stop();
        n_cmp++;
        if (acks !== model_wr_acks(a, n)) begin
          n_fail++; $display("FAIL rand_wr_acks[%0d]: addr %h got %b expected %b", t, a, acks, model_wr_acks(a, n));
        end
        n_cmp++;
        if (got_q.size() - b_got != exp_q.size()) begin
          n_fail++; $display("FAIL rand_wr_count[%0d]: got %0d expected %0d", t, got_q.size() - b_got, exp_q.size());
        end else begin
          for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[b_got + i] !== exp_q[i]) begin
              n_fail++; $display("FAIL rand_wr_data[%0d.%0d]: got %h expected %h", t, i, got_q[b_got + i], exp_q[i]);
            end
          end
        end
      end else begin
        for (int i = 0; i < n; i++) begin
          rd_bytes[4'(rd_ptr + i)] = 8'($urandom);
          exp_q.push_back(rd_bytes[4'(rd_ptr + i)]);
        end
        rd_xfer(a, n, ack);
        bus_stop();
        n_cmp++;
        if (ack !== (a == TGT)) begin n_fail++; $display("FAIL rand_rd_ack[%0d]: addr %h got %b expected %b", t, a, ack, a == TGT); end
        n_cmp++;
        if (n_rd_req - b_rd_req != ((a == TGT) ? n : 0) || n_nack - b_nack != ((a == TGT) ? 1 : 0)) begin
          n_fail++; $display("FAIL rand_rd_pulses[%0d]: rd_req %0d nack %0d", t, n_rd_req - b_rd_req, n_nack - b_nack);
        end
        if (a == TGT) begin
          for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (rx_bytes[i] !== exp_q[i]) begin
              n_fail++; $display("FAIL rand_rd_data[%0d.%0d]: got %h expected %h", t, i, rx_bytes[i], exp_q[i]);
            end
          end
        end
      end
      n_cmp++;
      if (busy_o !== 1'b0 || sda_drive_o !== 1'b0) begin
        n_fail++; $display("FAIL rand_end_idle[%0d]: busy %b drive %b expected 0/0", t, busy_o, sda_drive_o);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rd_bytes[i] = 8'h00;
    test_reset();
    test_write_basic();
    test_addr_miss();
    test_read();
    test_repeated_start();
    test_partial_stop();
    test_reset_during_ack();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
